transport_rx: RTL and testbench
===============================

Name: transport_rx

Overview:
- Receive half of the transport layer: turns the network-side byte stream into the `cmdIn`/`packetIn` word strobes that the session block consumes.
- Parses framed packets, filters them by destination phone number, verifies a checksum and delivers words to session under session's busy flag.
- Sits between the network byte interface and the session module; its outputs feed session's `cmdIn`, `packetIn` and `transportBusy` inputs.

Parameters:
- SYNC, 8'h7E, frame start byte.
- BCAST, 8'hFF, broadcast destination address, accepted by every phone.
- TIMEOUT, 1000, maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- myPhone  in  8  this unit's phone number.
- rxByte  in  8  received network byte.
- rxValid  in  1  `rxByte` valid for exactly this cycle.
- sessionBusy  in  1  session cannot accept a word this cycle.
- cmdOut  out  2  command strobe to session: 00 none, 01 control, 10 audio.
- packetOut  out  16  word accompanying `cmdOut`.
- transportBusy  out  1  a delivery is pending inside this block.
- frameErr  out  1  one-cycle pulse on any frame error.
- dropCount  out  8  saturating count of words lost to overflow.
- current_state  out  4  FSM state, for debug.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: `cmdOut`=0, `packetOut`=0, `transportBusy`=0, `frameErr`=0, `dropCount`=0, FSM in IDLE, pending register empty, checksum accumulator 0.
- Reset mid-frame aborts the frame. No output is produced for it.
- Frame format, in byte order:
  - SYNC
  - DEST
  - SRC
  - HDR: [7:6] type, [5:0] N
  - payload
  - CHK = XOR of DEST through the last payload byte
- Payload by type:
  - type 01 (control): exactly 1 code byte; N is ignored.
  - type 10 (audio): N words, each sent high byte then low byte.
- FSM states: IDLE, DEST, SRC, HDR, AUD_HI, AUD_LO, CTRL, CHK, SKIP.
  - The FSM advances only on `rxValid` cycles.
  - Cycles with `rxValid`=0 leave state unchanged, except for the timeout.
- IDLE: non-SYNC bytes are discarded. SYNC → DEST, checksum cleared.
- DEST: latch DEST. It matches when DEST = `myPhone` or DEST = BCAST.
- SRC: latch SRC.
- HDR decoding:
  - type 00 or 11 → `frameErr` pulse, go to IDLE.
  - type 10 with N=0 → `frameErr` pulse, go to IDLE.
  - DEST did not match → SKIP, with byte counter = payload length + 1 (2N+1 for audio, 2 for control).
  - Otherwise → CTRL (type 01) or AUD_HI (type 10).
- SKIP: decrement the counter per byte; go to IDLE at zero. No outputs and no `frameErr` for skipped frames.
- Audio delivery is streaming:
  - Completing an AUD_LO byte queues {hi, lo} as an audio word.
  - After N words → CHK; otherwise → AUD_HI.
- Control delivery is held:
  - CTRL latches the code byte, then → CHK.
  - {SRC, code} is queued only if CHK matches.
- CHK:
  - Mismatch → `frameErr` pulse; a control word is discarded. Audio words already delivered stay delivered.
  - Always → IDLE.
- Pending register (one entry):
  - When pending and `sessionBusy`=0, drive `cmdOut`/`packetOut` for exactly one cycle and clear pending.
  - While `sessionBusy`=1, `cmdOut`=00 and the word is held.
  - `transportBusy` = pending.
  - Latency: with `sessionBusy`=0, the strobe appears the cycle after the queuing byte's `rxValid` cycle.
- Overflow: if a word must be queued while one is still pending, the new word is dropped and `dropCount` increments, saturating at 255.
  - Same-cycle delivery and queue: the pending word issues and the new word is queued. No drop.
- `packetOut` holds its last value when `cmdOut`=00.
- Timeout: in any state except IDLE, TIMEOUT consecutive cycles without `rxValid` → `frameErr` pulse, go to IDLE.
  - A pending word is unaffected by the timeout.
- Timeout counter: resets on every `rxValid`; does not count in IDLE.
- SYNC inside a frame is ordinary data. Parsing is positional only.

Test Plan:
- `myPhone`=20, sessionBusy=0, bytes 7E 20 30 41 01 50 → one cycle after the CHK byte: `cmdOut`=01, `packetOut`=3001, `frameErr`=0.
- Same control frame with CHK=51 → `cmdOut` stays 00, `frameErr` pulses once, FSM returns to IDLE.
- Audio frame 7E 20 30 82 12 34 AB CD D2 → `cmdOut`=10 with `packetOut`=1234, then `cmdOut`=10 with `packetOut`=ABCD, each one cycle after its low byte. Repeat with CHK=00 → same two words delivered, plus a `frameErr` pulse.
- Frames with DEST=55 (skipped, no outputs) and DEST=FF (delivered), followed by a valid frame → only the broadcast frame and the valid frame are delivered; FSM back-to-back correct.
- Audio frame with bytes on consecutive cycles and `sessionBusy` held 1 throughout → the first word is held with `transportBusy`=1, the second is dropped, `dropCount`=1. Releasing `sessionBusy` delivers 1234.
- Stop after 7E 20 for TIMEOUT cycles → `frameErr` pulse, IDLE. Assert `reset` mid-audio-frame → all outputs return to reset values and the next valid frame parses correctly.

Source files
------------

// File: rtl/transport_rx_if.sv
// Purpose: groups the network byte strobe and the session word handshake of transport_rx.
// Latency: none, this only bundles wires.
// Backpressure: sessionBusy from session holds the pending word inside transport_rx.
// Ports:
//   rxByte/rxValid          network byte, valid for a single cycle
//   sessionBusy             session cannot take a word this cycle
//   cmdOut/packetOut        word strobe to session (00 none, 01 control, 10 audio)
//   transportBusy           a word is pending inside transport_rx
interface transport_rx_if;
  logic [7:0]  rxByte;
  logic        rxValid;
  logic        sessionBusy;
  logic [1:0]  cmdOut;
  logic [15:0] packetOut;
  logic        transportBusy;

  // master: the network/session side that drives bytes and busy
  modport master (
    output rxByte, rxValid, sessionBusy,
    input  cmdOut, packetOut, transportBusy
  );

  // slave: transport_rx itself
  modport slave (
    input  rxByte, rxValid, sessionBusy,
    output cmdOut, packetOut, transportBusy
  );
endinterface

// File: rtl/transport_rx.sv
// Purpose: parse framed network bytes, filter by destination, verify XOR checksum, hand words to session.
// Latency: a queued word strobes on cmdOut the cycle after the byte that completes it (if session is idle).
// Backpressure: one pending slot held while sessionBusy; a word arriving on a full slot is dropped and counted.
// Ports:
//   clk, reset (sync, active-high)   myPhone: this unit's address
//   bus (transport_rx_if.slave)      byte input and session word handshake
//   frameErr: one-cycle error pulse  dropCount: saturating overflow count  current_state: FSM debug
module transport_rx #(
  parameter logic [7:0] SYNC    = 8'h7E,
  parameter logic [7:0] BCAST   = 8'hFF,
  parameter int         TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    myPhone,
  transport_rx_if.slave bus,
  output logic          frameErr,
  output logic [7:0]    dropCount,
  output logic [3:0]    current_state
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    DEST   = 4'd1,
    SRC    = 4'd2,
    HDR    = 4'd3,
    AUD_HI = 4'd4,
    AUD_LO = 4'd5,
    CTRL   = 4'd6,
    CHK    = 4'd7,
    SKIP   = 4'd8
  } state_t;

  state_t        r_state;
  logic          r_match;     // DEST addressed this unit or broadcast
  logic          r_is_ctrl;   // current frame is a control frame
  logic [7:0]    r_src;
  logic [7:0]    r_code;
  logic [7:0]    r_hi;
  logic [7:0]    r_chk;       // running XOR from DEST onward
  logic [7:0]    r_cnt;       // bytes left to discard in SKIP
  logic [5:0]    r_n;         // audio word count from HDR
  logic [5:0]    r_wcnt;      // audio words completed so far
  logic [TW-1:0] r_tcnt;      // idle cycles inside a frame

  logic          r_pend;
  logic [1:0]    r_pcmd;
  logic [15:0]   r_pdat;
  logic [15:0]   r_last;      // packetOut value held between strobes

  logic          w_deliver;
  logic          w_q_vld;
  logic [1:0]    w_q_cmd;
  logic [15:0]   w_q_dat;
  logic [1:0]    w_type;
  logic [5:0]    w_n;

  assign w_type = bus.rxByte[7:6];
  assign w_n    = bus.rxByte[5:0];

  // Word to queue this cycle: each audio low byte, or a control word whose CHK matched.
  always_comb begin
    w_q_vld = 1'b0;
    w_q_cmd = 2'b00;
    w_q_dat = 16'h0000;
    if (bus.rxValid) begin
      if (r_state == AUD_LO) begin
        w_q_vld = 1'b1;
        w_q_cmd = 2'b10;
        w_q_dat = {r_hi, bus.rxByte};
      end else if (r_state == CHK && r_is_ctrl && r_chk == bus.rxByte) begin
        w_q_vld = 1'b1;
        w_q_cmd = 2'b01;
        w_q_dat = {r_src, r_code};
      end
    end
  end

  // Frame parser. Only rxValid cycles advance it; idle cycles only feed the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_match   <= 1'b0;
      r_is_ctrl <= 1'b0;
      r_src     <= 8'h00;
      r_code    <= 8'h00;
      r_hi      <= 8'h00;
      r_chk     <= 8'h00;
      r_cnt     <= 8'h00;
      r_n       <= 6'd0;
      r_wcnt    <= 6'd0;
      r_tcnt    <= '0;
      frameErr  <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      if (!bus.rxValid) begin
        if (r_state != IDLE) begin
          if (r_tcnt == T_LAST) begin
            frameErr <= 1'b1;
            r_state  <= IDLE;
            r_tcnt   <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
      end else begin
        r_tcnt <= '0;
        case (r_state)
          IDLE: begin
            if (bus.rxByte == SYNC) begin
              r_state <= DEST;
              r_chk   <= 8'h00;
            end
          end
          DEST: begin
            r_match <= (bus.rxByte == myPhone) || (bus.rxByte == BCAST);
            r_chk   <= r_chk ^ bus.rxByte;
            r_state <= SRC;
          end
          SRC: begin
            r_src   <= bus.rxByte;
            r_chk   <= r_chk ^ bus.rxByte;
            r_state <= HDR;
          end
          HDR: begin
            r_chk     <= r_chk ^ bus.rxByte;
            r_n       <= w_n;
            r_wcnt    <= 6'd0;
            r_is_ctrl <= (w_type == 2'b01);
            if (w_type == 2'b01) begin
              if (r_match) begin
                r_state <= CTRL;
              end else begin
                r_state <= SKIP;
                r_cnt   <= 8'd2;            // code byte + CHK
              end
            end else if (w_type == 2'b10 && w_n != 6'd0) begin
              if (r_match) begin
                r_state <= AUD_HI;
              end else begin
                r_state <= SKIP;
                r_cnt   <= {1'b0, w_n, 1'b1}; // 2N payload bytes + CHK
              end
            end else begin
              frameErr <= 1'b1;
              r_state  <= IDLE;
            end
          end
          AUD_HI: begin
            r_hi    <= bus.rxByte;
            r_chk   <= r_chk ^ bus.rxByte;
            r_state <= AUD_LO;
          end
          AUD_LO: begin
            r_chk  <= r_chk ^ bus.rxByte;
            r_wcnt <= r_wcnt + 6'd1;
            if (r_wcnt + 6'd1 == r_n) r_state <= CHK;
            else                      r_state <= AUD_HI;
          end
          CTRL: begin
            r_code  <= bus.rxByte;
            r_chk   <= r_chk ^ bus.rxByte;
            r_state <= CHK;
          end
          CHK: begin
            // Audio words already went out; a mismatch only flags the frame.
            if (r_chk != bus.rxByte) frameErr <= 1'b1;
            r_state <= IDLE;
          end
          SKIP: begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Single-entry pending slot. A delivery in the same cycle frees the slot for the new word.
  assign w_deliver = r_pend && !bus.sessionBusy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_pcmd    <= 2'b00;
      r_pdat    <= 16'h0000;
      r_last    <= 16'h0000;
      dropCount <= 8'h00;
    end else begin
      if (w_deliver) begin
        r_last <= r_pdat;
        r_pend <= 1'b0;
      end
      if (w_q_vld) begin
        if (r_pend && !w_deliver) begin
          if (dropCount != 8'hFF) dropCount <= dropCount + 8'h01;
        end else begin
          r_pend <= 1'b1;
          r_pcmd <= w_q_cmd;
          r_pdat <= w_q_dat;
        end
      end
    end
  end

  assign bus.cmdOut        = w_deliver ? r_pcmd : 2'b00;
  assign bus.packetOut     = w_deliver ? r_pdat : r_last;
  assign bus.transportBusy = r_pend;
  assign current_state     = r_state;

endmodule

// File: tb/tb_transport_rx.sv
// Purpose: drive framed byte streams into transport_rx and compare every cycle against a frame-level model.
// Latency: model predicts the strobe the cycle after the completing byte.
// Backpressure: sessionBusy held or randomized; model tracks the single pending slot and drops.
module tb_transport_rx;
  localparam int         TIMEOUT = 1000;
  localparam logic [7:0] SYNC    = 8'h7E;
  localparam logic [7:0] MY      = 8'h20;
  localparam logic [7:0] BC      = 8'hFF;

  logic       clk;
  logic       reset;
  logic [7:0] my_phone;
  logic       frame_err;
  logic [7:0] drop_count;
  logic [3:0] cur_state;

  transport_rx_if ifc();

  transport_rx #(.SYNC(SYNC), .BCAST(BC), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .myPhone       (my_phone),
    .bus           (ifc),
    .frameErr      (frame_err),
    .dropCount     (drop_count),
    .current_state (cur_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic sb_rand = 1'b0;
  logic sb_hold = 1'b0;

  // Model state: frame bytes seen since SYNC, interpreted by position.
  logic        m_in;
  logic [7:0]  m_fr[$];
  int          m_idle;
  logic        m_pend;
  logic [1:0]  m_pcmd;
  logic [15:0] m_pdat;
  logic [15:0] m_last;
  int          m_drop;
  logic        m_ferr;

  logic [1:0]  obs_cmd[$];
  logic [15:0] obs_dat[$];
  int          ferr_cnt = 0;
  logic [7:0]  txq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic       dlv;
    logic [1:0] ec;
    logic [15:0] ep;
    dlv = m_pend && !ifc.sessionBusy;
    ec  = dlv ? m_pcmd : 2'b00;
    ep  = dlv ? m_pdat : m_last;
    check("cmdOut",        32'(ifc.cmdOut),        32'(ec));
    check("packetOut",     32'(ifc.packetOut),     32'(ep));
    check("transportBusy", 32'(ifc.transportBusy), 32'(m_pend));
    check("frameErr",      32'(frame_err),         32'(m_ferr));
    check("dropCount",     32'(drop_count),        32'(m_drop));
    if (ifc.cmdOut != 2'b00) begin
      obs_cmd.push_back(ifc.cmdOut);
      obs_dat.push_back(ifc.packetOut);
    end
    if (frame_err) ferr_cnt++;
  endtask

  task automatic model_step();
    logic        qv, err, match;
    logic [1:0]  qc;
    logic [15:0] qd;
    logic [7:0]  b, hdr, x;
    int          n, plen;
    qv = 1'b0; qc = 2'b00; qd = 16'h0; err = 1'b0; b = ifc.rxByte;
    if (reset) begin
      m_in = 1'b0; m_fr.delete(); m_idle = 0;
      m_pend = 1'b0; m_pcmd = 2'b00; m_pdat = 16'h0; m_last = 16'h0;
      m_drop = 0; m_ferr = 1'b0;
    end else begin
      if (m_pend && !ifc.sessionBusy) begin
        m_last = m_pdat;
        m_pend = 1'b0;
      end
      if (ifc.rxValid) begin
        m_idle = 0;
        if (!m_in) begin
          if (b == SYNC) begin
            m_in = 1'b1;
            m_fr.delete();
          end
        end else begin
          m_fr.push_back(b);
          n = m_fr.size();
          if (n >= 3) begin
            hdr   = m_fr[2];
            match = (m_fr[0] == MY) || (m_fr[0] == BC);
            plen  = (hdr[7:6] == 2'b01) ? 1 : 2 * int'(hdr[5:0]);
            if (n == 3) begin
              if (hdr[7:6] == 2'b00 || hdr[7:6] == 2'b11 || (hdr[7:6] == 2'b10 && hdr[5:0] == 6'd0)) begin
                err = 1'b1;
                m_in = 1'b0;
              end
            end else if (n == plen + 4) begin
              if (match) begin
                x = 8'h00;
                for (int i = 0; i < n - 1; i++) x = x ^ m_fr[i];
                if (x != b) err = 1'b1;
                else if (hdr[7:6] == 2'b01) begin
                  qv = 1'b1; qc = 2'b01; qd = {m_fr[1], m_fr[3]};
                end
              end
              m_in = 1'b0;
            end else if (match && hdr[7:6] == 2'b10 && ((n - 3) % 2) == 0) begin
              qv = 1'b1; qc = 2'b10; qd = {m_fr[n-2], m_fr[n-1]};
            end
          end
        end
      end else if (m_in) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          err = 1'b1;
          m_in = 1'b0;
          m_idle = 0;
        end
      end
      if (qv) begin
        if (m_pend) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_pend = 1'b1; m_pcmd = qc; m_pdat = qd;
        end
      end
      m_ferr = err;
    end
  endtask

  // One clock cycle: compare and step the model at negedge, then update sessionBusy after posedge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) compare();
    model_step();
    @(posedge clk);
    #1;
    ifc.sessionBusy = sb_rand ? ($urandom_range(0, 3) == 0) : sb_hold;
    #1;
  endtask

  task automatic run_tx(input int gapmax);
    while (txq.size() > 0) begin
      ifc.rxValid = 1'b1;
      ifc.rxByte  = txq.pop_front();
      tick();
      ifc.rxValid = 1'b0;
      ifc.rxByte  = 8'($urandom);
      repeat ($urandom_range(0, gapmax)) tick();
    end
  endtask

  task automatic idle(input int n);
    ifc.rxValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic push(input logic [7:0] b);
    txq.push_back(b);
  endtask

  task automatic rand_frame();
    logic [7:0] dest, hdr, x, g;
    logic [7:0] body[$];
    int sel, keep;
    logic bad;
    repeat ($urandom_range(0, 2)) begin
      g = 8'($urandom);
      if (g == SYNC) g = 8'h00;
      push(g);
    end
    sel = $urandom_range(0, 3);
    dest = (sel < 2) ? MY : (sel == 2) ? BC : 8'($urandom);
    body.push_back(dest);
    body.push_back(8'($urandom));
    sel = $urandom_range(0, 9);
    bad = 1'b0;
    if (sel == 0) begin
      hdr = {($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, 6'($urandom)};
      bad = 1'b1;
    end else if (sel < 5) begin
      hdr = {2'b01, 6'($urandom)};
    end else begin
      hdr = {2'b10, 6'($urandom_range(0, 4))};
      if (hdr[5:0] == 6'd0) bad = 1'b1;
    end
    body.push_back(hdr);
    if (!bad) begin
      if (hdr[7:6] == 2'b01) body.push_back(8'($urandom));
      else repeat (2 * int'(hdr[5:0])) body.push_back(8'($urandom));
    end
    x = 8'h00;
    foreach (body[i]) x = x ^ body[i];
    if ($urandom_range(0, 5) == 0) x = x ^ 8'h5A;
    push(SYNC);
    if ($urandom_range(0, 39) == 0) begin
      keep = $urandom_range(1, body.size());
      for (int i = 0; i < keep; i++) push(body[i]);
      run_tx($urandom_range(0, 2));
      idle(TIMEOUT + 3);
    end else begin
      foreach (body[i]) push(body[i]);
      if (!bad) push(x);
      run_tx($urandom_range(0, 2));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired state=%0d", cur_state);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, f;
    my_phone = MY;
    reset = 1'b1;
    ifc.rxValid = 1'b0;
    ifc.rxByte = 8'h00;
    ifc.sessionBusy = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    tick();
    check("rst_cmdOut",        32'(ifc.cmdOut),        32'd0);
    check("rst_packetOut",     32'(ifc.packetOut),     32'd0);
    check("rst_transportBusy", 32'(ifc.transportBusy), 32'd0);
    check("rst_dropCount",     32'(drop_count),        32'd0);

    // Control frame, good checksum: strobe the cycle after CHK.
    txq = '{8'h7E, 8'h20, 8'h30, 8'h41, 8'h01, 8'h50};
    run_tx(0);
    check("ctrl_cmdOut",    32'(ifc.cmdOut),    32'd1);
    check("ctrl_packetOut", 32'(ifc.packetOut), 32'h3001);
    check("ctrl_frameErr",  32'(frame_err),     32'd0);
    idle(2);

    // Control frame, bad checksum: no word, one error pulse.
    s = obs_cmd.size(); f = ferr_cnt;
    txq = '{8'h7E, 8'h20, 8'h30, 8'h41, 8'h01, 8'h51};
    run_tx(0);
    check("badctrl_cmdOut",   32'(ifc.cmdOut), 32'd0);
    check("badctrl_frameErr", 32'(frame_err),  32'd1);
    idle(2);
    check("badctrl_words",  32'(obs_cmd.size() - s), 32'd0);
    check("badctrl_errcnt", 32'(ferr_cnt - f),       32'd1);

    // Audio frame, good then bad checksum: words stream out either way.
    for (int pass = 0; pass < 2; pass++) begin
      s = obs_cmd.size(); f = ferr_cnt;
      txq = '{8'h7E, 8'h20, 8'h30, 8'h82, 8'h12, 8'h34, 8'hAB, 8'hCD, (pass == 0) ? 8'hD2 : 8'h00};
      run_tx(1);
      idle(2);
      check("aud_words",  32'(obs_cmd.size() - s), 32'd2);
      check("aud_w0",     32'({obs_cmd[s], obs_dat[s]}),     32'h21234);
      check("aud_w1",     32'({obs_cmd[s+1], obs_dat[s+1]}), 32'h2ABCD);
      check("aud_errcnt", 32'(ferr_cnt - f), (pass == 0) ? 32'd0 : 32'd1);
    end

    // Skipped, broadcast and own frame back to back.
    s = obs_cmd.size(); f = ferr_cnt;
    txq = '{8'h7E, 8'h55, 8'h30, 8'h41, 8'h01, 8'h00,
            8'h7E, 8'hFF, 8'h30, 8'h41, 8'h02, 8'h8C,
            8'h7E, 8'h20, 8'h31, 8'h41, 8'h07, 8'h57};
    run_tx(0);
    idle(2);
    check("b2b_words",  32'(obs_cmd.size() - s), 32'd2);
    check("b2b_w0",     32'({obs_cmd[s], obs_dat[s]}),     32'h13002);
    check("b2b_w1",     32'({obs_cmd[s+1], obs_dat[s+1]}), 32'h13107);
    check("b2b_errcnt", 32'(ferr_cnt - f), 32'd0);

    // Overflow: session busy throughout, second audio word dropped.
    sb_hold = 1'b1;
    idle(1);
    s = obs_cmd.size();
    txq = '{8'h7E, 8'h20, 8'h30, 8'h82, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hD2};
    run_tx(0);
    idle(1);
    check("ovf_dropCount",     32'(drop_count),          32'd1);
    check("ovf_transportBusy", 32'(ifc.transportBusy),   32'd1);
    check("ovf_held",          32'(obs_cmd.size() - s),  32'd0);
    sb_hold = 1'b0;
    idle(3);
    check("ovf_words", 32'(obs_cmd.size() - s), 32'd1);
    check("ovf_w0",    32'({obs_cmd[s], obs_dat[s]}), 32'h21234);

    // Reset mid audio frame, then a fresh frame parses.
    txq = '{8'h7E, 8'h20, 8'h30, 8'h82, 8'h12, 8'h34, 8'hAB};
    run_tx(0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_cmdOut",        32'(ifc.cmdOut),        32'd0);
    check("mid_rst_packetOut",     32'(ifc.packetOut),     32'd0);
    check("mid_rst_transportBusy", 32'(ifc.transportBusy), 32'd0);
    check("mid_rst_frameErr",      32'(frame_err),         32'd0);
    check("mid_rst_dropCount",     32'(drop_count),        32'd0);
    s = obs_cmd.size();
    txq = '{8'h7E, 8'h20, 8'h30, 8'h81, 8'h55, 8'h66, 8'hA2};
    run_tx(0);
    idle(2);
    check("post_rst_words", 32'(obs_cmd.size() - s), 32'd1);
    check("post_rst_w0",    32'({obs_cmd[s], obs_dat[s]}), 32'h25566);

    // Timeout after SYNC DEST.
    f = ferr_cnt;
    txq = '{8'h7E, 8'h20};
    run_tx(0);
    idle(TIMEOUT - 2);
    check("timeout_early", 32'(ferr_cnt - f), 32'd0);
    idle(4);
    check("timeout_err",   32'(ferr_cnt - f), 32'd1);
    s = obs_cmd.size();
    txq = '{8'h7E, 8'h20, 8'h30, 8'h41, 8'h01, 8'h50};
    run_tx(0);
    idle(2);
    check("timeout_next", 32'({obs_cmd[s], obs_dat[s]}), 32'h13001);

    // Randomized frames with random gaps and random session backpressure.
    sb_rand = 1'b1;
    for (int k = 0; k < 150; k++) rand_frame();
    sb_rand = 1'b0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
